chaotic_seq_gen_mc: RTL

Multi-channel, parametrised Lorenz-system sequence generator, the successor to the single-channel `chaotic_seq_gen`. It keeps one fixed-point Euler-step datapath, time-multiplexes it across `channels` independent trajectories and gates output through a valid/ready stream. It adds start/stop control, per-channel seed offsets, saturating arithmetic and a sticky overflow flag. It sits between the key/seed control logic and downstream whitening/packing logic, all in the `clkSlow` domain.

---
 rtl/chaotic_seq_gen_mc.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/chaotic_seq_gen_mc.sv
// rtl/chaotic_seq_gen_mc.sv - multi-channel time-multiplexed Lorenz sequence generator
// One saturating fixed-point Euler datapath shared round-robin across all channels.

module chaotic_seq_gen_mc #(
  parameter int integerBits  = 6,
  parameter int fractionBits = 25,
  parameter int dtBits       = 20,
  parameter int dtShift      = 32,
  parameter int iteratorBits = 18,
  parameter int channels     = 4,
  parameter int sigma        = 335544320,
  parameter int beta         = 89478485,
  parameter int rho          = 939524096,
  parameter int seedStep     = 1,
  localparam int totalBits   = 1 + integerBits + fractionBits,
  localparam int chW         = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                          clkSlow,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          stop,
  input  logic signed [dtBits-1:0]      dt,
  input  logic [iteratorBits-1:0]       skip,
  input  logic signed [totalBits-1:0]   seedX,
  input  logic signed [totalBits-1:0]   seedY,
  input  logic signed [totalBits-1:0]   seedZ,
  output logic                          busy,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [chW-1:0]                outChan,
  output logic signed [totalBits-1:0]   x,
  output logic signed [totalBits-1:0]   y,
  output logic signed [totalBits-1:0]   z,
  output logic                          ovf
);

  typedef logic signed [totalBits-1:0]   word_t;
  typedef logic signed [2*totalBits-1:0] wide_t;
  typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;

  localparam wide_t    SMAX    = (wide_t'(1) <<< (totalBits - 1)) - wide_t'(1);
  localparam wide_t    SMIN    = -(wide_t'(1) <<< (totalBits - 1));
  localparam [chW-1:0] LAST_CH = chW'(channels - 1);

  function automatic word_t clip(input wide_t v);
    if (v > SMAX)      clip = SMAX[totalBits-1:0];
    else if (v < SMIN) clip = SMIN[totalBits-1:0];
    else               clip = v[totalBits-1:0];
  endfunction

  function automatic logic over(input wide_t v);
    over = (v > SMAX) || (v < SMIN);
  endfunction

  function automatic wide_t ext(input word_t v);
    ext = wide_t'(v);
  endfunction

  // Full-width signed product followed by a flooring arithmetic shift.
  function automatic wide_t mulsh(input wide_t a, input wide_t b, input int sh);
    wide_t p;
    p = a * b;
    mulsh = p >>> sh;
  endfunction

  state_t                   state, state_n;
  logic [chW-1:0]           ch;
  logic [iteratorBits-1:0]  iter, skip_q;
  logic signed [dtBits-1:0] dt_q;
  word_t                    xs [channels];
  word_t                    ys [channels];
  word_t                    zs [channels];

  logic                     ch_last, load_seeds, step_en, emit_enter, accept, use_new;
  logic [chW-1:0]           out_idx;
  word_t                    ox, oy, oz;

  word_t cx, cy, cz, a_yx, a_rz, t_xr, t_xy, t_bz, dxv, dyv, dzv, nx, ny, nz;
  wide_t dtw, s_yx, p_dx, s_rz, p_xr, s_dy, p_xy, p_bz, s_dz, s_nx, s_ny, s_nz;
  logic  step_ovf;

  assign ch_last = (ch == LAST_CH);
  assign busy    = (state != IDLE);

  always_ff @(posedge clkSlow or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (ch_last && (iter == skip_q)) state_n = EMIT;
      EMIT:    if (outReady && ch_last) state_n = RUN;
      default: state_n = IDLE;
    endcase
    if (stop) state_n = IDLE;
  end

  always_comb begin
    load_seeds = (state == IDLE) && start && !stop;
    step_en    = (state == RUN) && !stop;
    emit_enter = step_en && ch_last && (iter == skip_q);
    accept     = (state == EMIT) && outReady && !stop;
    out_idx    = emit_enter ? '0 : ch + chW'(1);
    // With a single channel the sample being emitted is the one updated on this edge.
    use_new    = emit_enter && (ch == out_idx);
  end

  always_comb begin
    cx   = xs[ch];
    cy   = ys[ch];
    cz   = zs[ch];
    dtw  = wide_t'(dt_q);
    s_yx = ext(cy) - ext(cx);
    a_yx = clip(s_yx);
    p_dx = mulsh(wide_t'(sigma), ext(a_yx), fractionBits);
    dxv  = clip(p_dx);
    s_rz = wide_t'(rho) - ext(cz);
    a_rz = clip(s_rz);
    p_xr = mulsh(ext(cx), ext(a_rz), fractionBits);
    t_xr = clip(p_xr);
    s_dy = ext(t_xr) - ext(cy);
    dyv  = clip(s_dy);
    p_xy = mulsh(ext(cx), ext(cy), fractionBits);
    t_xy = clip(p_xy);
    p_bz = mulsh(wide_t'(beta), ext(cz), fractionBits);
    t_bz = clip(p_bz);
    s_dz = ext(t_xy) - ext(t_bz);
    dzv  = clip(s_dz);
    s_nx = ext(cx) + mulsh(ext(dxv), dtw, dtShift);
    s_ny = ext(cy) + mulsh(ext(dyv), dtw, dtShift);
    s_nz = ext(cz) + mulsh(ext(dzv), dtw, dtShift);
    nx   = clip(s_nx);
    ny   = clip(s_ny);
    nz   = clip(s_nz);
    step_ovf = over(s_yx) | over(p_dx) | over(s_rz) | over(p_xr) | over(s_dy) |
               over(p_xy) | over(p_bz) | over(s_dz) | over(s_nx) | over(s_ny) | over(s_nz);
    ox = use_new ? nx : xs[out_idx];
    oy = use_new ? ny : ys[out_idx];
    oz = use_new ? nz : zs[out_idx];
  end

  always_ff @(posedge clkSlow or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < channels; k++) begin
        xs[k] <= '0;
        ys[k] <= '0;
        zs[k] <= '0;
      end
      dt_q     <= '0;
      skip_q   <= '0;
      ch       <= '0;
      iter     <= '0;
      ovf      <= 1'b0;
      outValid <= 1'b0;
      outChan  <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
    end else begin
      if (load_seeds) begin
        for (int k = 0; k < channels; k++) begin
          xs[k] <= seedX + totalBits'(k * seedStep);
          ys[k] <= seedY;
          zs[k] <= seedZ;
        end
        dt_q   <= dt;
        skip_q <= skip;
        ovf    <= 1'b0;
        ch     <= '0;
        iter   <= '0;
      end else if (step_en) begin
        xs[ch] <= nx;
        ys[ch] <= ny;
        zs[ch] <= nz;
        ovf    <= ovf | step_ovf;
        if (ch_last) begin
          ch <= '0;
          if (iter == skip_q) iter <= '0;
          else                iter <= iter + iteratorBits'(1);
        end else begin
          ch <= ch + chW'(1);
        end
      end else if (accept) begin
        ch <= ch_last ? '0 : ch + chW'(1);
      end

      if (stop) begin
        outValid <= 1'b0;
      end else if (emit_enter || (accept && !ch_last)) begin
        outValid <= 1'b1;
        outChan  <= out_idx;
        x        <= ox;
        y        <= oy;
        z        <= oz;
      end else if (accept) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule
